key_conditioner: RTL and testbench

//  Conditions the four raw active-low KEY pushbuttons into clean single-cycle command pulses
//  (o_select/o_back/o_up/o_down) for the menu/EQ control FSM in top. Sits directly upstream of it.
//  Per key: 2-flop synchronizer, counter debounce, press-edge detect. At most one command pulse per cycle.

---
 rtl/key_conditioner.sv | 136 +++++++++++++
 tb/tb_key_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//   Turns the four raw active-low KEY pushbuttons into clean one-cycle command
//   pulses for the menu/EQ control FSM. Each key has a 2-flop synchronizer, a
//   counter debounce and a press-edge detector. At most one command pulse is
//   high in any cycle.
//
//   Optional feature (macro KEY_AUTOREPEAT_EN): hold-to-repeat on up/down.
//   Without the macro there is no repeat logic and each debounced press gives
//   exactly one pulse.
//
// Ports
//   i_clk     BCLK domain clock
//   i_rst     synchronous reset, active-high
//   i_key_n   raw KEY[3:0], active-low, async: [3]=select [2]=back [1]=up [0]=down
//   o_select  one-cycle press pulse
//   o_back    one-cycle press pulse
//   o_up      one-cycle press / repeat pulse
//   o_down    one-cycle press / repeat pulse
//   o_held    debounced level per key, 1 = pressed, same bit order as i_key_n
//
// Handshake: none. Outputs are registered level/pulse signals and have no
// backpressure; a command pulse that loses arbitration is dropped.
module key_conditioner #(
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_n,
    output logic       o_select,
    output logic       o_back,
    output logic       o_up,
    output logic       o_down,
    output logic [3:0] o_held
);

    localparam int            DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC);

    logic [3:0]    sync1_n;
    logic [3:0]    sync2_n;
    logic [3:0]    s;
    logic [3:0]    stable;
    logic [DW-1:0] cnt [4];
    logic [3:0]    accept;
    logic [3:0]    press;
    logic [3:0]    release_ev;
    logic [1:0]    rep;
    logic [3:0]    ev;

    // Synchronized level, 1 = pressed.
    assign s      = ~sync2_n;
    assign o_held = stable;

    // A new level is accepted on the edge after the counter has seen it
    // differ from the stable level for DEBOUNCE_CYC consecutive samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            accept[i] = (s[i] != stable[i]) && (cnt[i] == DB_LAST);
        end
        press      = accept & s;
        release_ev = accept & ~s;
        ev         = press | {2'b00, rep};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_n <= 4'hF;
            sync2_n <= 4'hF;
            stable  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            o_select <= 1'b0;
            o_back   <= 1'b0;
            o_up     <= 1'b0;
            o_down   <= 1'b0;
        end else begin
            sync1_n <= i_key_n;
            sync2_n <= sync1_n;
            for (int i = 0; i < 4; i++) begin
                if (s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            // Fixed priority back > select > up > down; losers are dropped.
            o_back   <= ev[2];
            o_select <= ev[3] & ~ev[2];
            o_up     <= ev[1] & ~(|ev[3:2]);
            o_down   <= ev[0] & ~(|ev[3:1]);
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int            RW     = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] R_FIRE = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    // rcnt[0] = down, rcnt[1] = up. The repeat fires on the edge where rcnt
    // would step to REPEAT_DELAY; the reload keeps it below that, so the
    // next repeat lands REPEAT_PERIOD cycles later and it never wraps.
    logic [RW-1:0] rcnt [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep[i] = stable[i] && !release_ev[i] && (rcnt[i] == R_FIRE);
        end
        // With both held, only up repeats.
        rep[0] = rep[0] & ~stable[1];
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (i_rst || !stable[i] || press[i] || (i == 0 && stable[1])) begin
                rcnt[i] <= '0;
            end else if (rep[i]) begin
                rcnt[i] <= R_LOAD;
            end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
            end
        end
    end
`else
    logic unused_repeat_cfg;

    assign rep               = 2'b00;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic       o_select;
  logic       o_back;
  logic       o_up;
  logic       o_down;
  logic [3:0] o_held;

  int total;
  int bad;

  key_conditioner #(
    .DEBOUNCE_CYC (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_n),
    .o_select(o_select),
    .o_back  (o_back),
    .o_up    (o_up),
    .o_down  (o_down),
    .o_held  (o_held)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key_n;
    int         cycles;
    int         n_sel;
    int         n_back;
    int         n_up;
    int         n_down;
    logic [3:0] held;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot", (32'(o_select) + 32'(o_back) + 32'(o_up) + 32'(o_down)) > 1, 0);
  endtask

  task automatic run_vec(input int idx);
    int ns, nb, nu, nd;
    ns = 0; nb = 0; nu = 0; nd = 0;
    key_n = vecs[idx].key_n;
    for (int c = 0; c < vecs[idx].cycles; c++) begin
      tick();
      ns += 32'(o_select);
      nb += 32'(o_back);
      nu += 32'(o_up);
      nd += 32'(o_down);
    end
    check($sformatf("v%0d_select", idx), ns, vecs[idx].n_sel);
    check($sformatf("v%0d_back", idx), nb, vecs[idx].n_back);
    check($sformatf("v%0d_up", idx), nu, vecs[idx].n_up);
    check($sformatf("v%0d_down", idx), nd, vecs[idx].n_down);
    check($sformatf("v%0d_held", idx), 32'(o_held), 32'(vecs[idx].held));
  endtask

  initial begin
    int exp;
    total = 0;
    bad   = 0;

    //                  key_n  cyc sel back up dn held
    vecs[0]  = '{4'hF, 50, 0, 0, 0, 0, 4'h0};  // idle
    vecs[1]  = '{4'h7,  3, 0, 0, 0, 0, 4'h0};  // select bounce, 3 cycles low
    vecs[2]  = '{4'hF, 10, 0, 0, 0, 0, 4'h0};  // ... never accepted
    vecs[3]  = '{4'h3, 12, 0, 1, 0, 0, 4'hC};  // back+select together
    vecs[4]  = '{4'hF, 12, 0, 0, 0, 0, 4'h0};
    vecs[5]  = '{4'hB, 12, 0, 1, 0, 0, 4'h4};  // back alone
    vecs[6]  = '{4'hF, 12, 0, 0, 0, 0, 4'h0};
    vecs[7]  = '{4'h7, 12, 1, 0, 0, 0, 4'h8};  // select alone
    vecs[8]  = '{4'hF, 12, 0, 0, 0, 0, 4'h0};
    vecs[9]  = '{4'hD, 12, 0, 0, 1, 0, 4'h2};  // up alone
    vecs[10] = '{4'hF, 12, 0, 0, 0, 0, 4'h0};
    vecs[11] = '{4'hC, 12, 0, 0, 1, 0, 4'h3};  // up+down together
    vecs[12] = '{4'hF, 12, 0, 0, 0, 0, 4'h0};

    // reset
    rst   = 1'b1;
    key_n = 4'hF;
    tick(); tick(); tick();
    check("rst_select", 32'(o_select), 0);
    check("rst_back", 32'(o_back), 0);
    check("rst_up", 32'(o_up), 0);
    check("rst_down", 32'(o_down), 0);
    check("rst_held", 32'(o_held), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(i);
    end

    // exact latency: down falls before edge 0, pulse only after edge 6
    key_n = 4'hE;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("lat_down_k%0d", k), 32'(o_down), 32'(k == 6));
    end
    check("lat_held", 32'(o_held), 1);
    key_n = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("lat_rel_k%0d", k), 32'(o_down), 0);
    end
    check("lat_rel_held", 32'(o_held), 0);

    // reset two cycles into the up debounce count
    key_n = 4'hD;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rmid_pre_k%0d", k), 32'(o_up), 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rmid_rst_k%0d", k), 32'(o_up), 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rmid_post_k%0d", k), 32'(o_up), 32'(k == 6));
    end
    key_n = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("rmid_rel_k%0d", k), 32'(o_up), 0);
    end
    check("rmid_rel_held", 32'(o_held), 0);

    // hold up ~58 cycles: press at 6, repeats at 26, 31, ... when enabled
    key_n = 4'hD;
    for (int k = 0; k < 80; k++) begin
      tick();
      exp = (k == 6) ? 1 : 0;
`ifdef KEY_AUTOREPEAT_EN
      if (k >= 6 + RD && k <= 61 && ((k - 6 - RD) % RP) == 0) exp = 1;
`endif
      check($sformatf("rep_up_k%0d", k), 32'(o_up), exp);
      if (k == 57) key_n = 4'hF;
    end
    check("rep_held", 32'(o_held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
